// File: rtl/sauria_cfg_shadow.sv
// Double-buffered configuration register set: words are staged into a shadow bank, then applied atomically once the engine is idle.
// Define SAURIA_CFG_READBACK_EN to add a registered readback port into the shadow bank.
module sauria_cfg_shadow #(
  parameter int N_REGS = 8,
  parameter int LAST_W = 32,
  localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [31:0]            i_cfg_wdata,
  input  logic                   i_cfg_wvalid,
  output logic                   o_cfg_wready,
  input  logic                   i_cfg_commit,
  input  logic                   i_eng_busy,
  output logic [N_REGS*32-1:0]   o_cfg_vector,
  output logic                   o_cfg_update,
  output logic                   o_cfg_pending,
  output logic                   o_cfg_err
`ifdef SAURIA_CFG_READBACK_EN
  ,
  input  logic [AW-1:0]          i_cfg_raddr,
  output logic [31:0]            o_cfg_rdata
`endif
);

  localparam logic [31:0] LAST_MASK = 32'hFFFF_FFFF >> (32 - LAST_W);
  localparam logic [AW-1:0] WCNT_LAST = AW'(N_REGS - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FULL  = 2'd1,
    ARMED = 2'd2,
    XFER  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [AW-1:0]                wcnt_reg, wcnt_next;
  logic [N_REGS-1:0][31:0]      shadow_reg, shadow_next;
  logic [N_REGS-1:0][31:0]      active_reg;
  logic                         err_reg;

  logic wready;
  logic pending;
  logic update;
  logic wr_en;
  logic wr_last;

  assign wr_en   = i_cfg_wvalid & wready;
  assign wr_last = wr_en && (wcnt_reg == WCNT_LAST);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (wr_last)       state_next = FULL;
      FULL:    if (i_cfg_commit)  state_next = ARMED;
      ARMED:   if (!i_eng_busy)   state_next = XFER;
      // Busy re-asserting in the transfer cycle defers the copy so the
      // active set can never change under a running engine.
      XFER:    state_next = i_eng_busy ? ARMED : LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Output logic
  always_comb begin
    wready  = 1'b0;
    pending = 1'b0;
    update  = 1'b0;
    case (state_reg)
      LOAD:    wready  = 1'b1;
      FULL:    pending = 1'b1;
      ARMED:   pending = 1'b1;
      XFER:    update  = !i_eng_busy;
      default: wready  = 1'b0;
    endcase
  end

  assign wcnt_next = wr_en ? (wr_last ? '0 : wcnt_reg + 1'b1) : wcnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_word
      localparam logic [31:0] WORD_MASK = (gi == N_REGS - 1) ? LAST_MASK : 32'hFFFF_FFFF;
      assign shadow_next[gi] = (wr_en && (wcnt_reg == AW'(gi))) ? (i_cfg_wdata & WORD_MASK)
                                                                  : shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wcnt_reg   <= '0;
      shadow_reg <= '0;
      active_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      wcnt_reg   <= wcnt_next;
      shadow_reg <= shadow_next;
      if (update) begin
        active_reg <= shadow_reg;
      end
      // A commit against an incomplete set is a sticky error.
      if (i_cfg_commit && (state_reg == LOAD)) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign o_cfg_wready  = wready;
  assign o_cfg_pending = pending;
  assign o_cfg_update  = update;
  assign o_cfg_err     = err_reg;
  assign o_cfg_vector  = active_reg;

`ifdef SAURIA_CFG_READBACK_EN
  logic [31:0] rdata_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_reg <= '0;
    end else if ({{(32-AW){1'b0}}, i_cfg_raddr} < 32'(N_REGS)) begin
      rdata_reg <= shadow_reg[i_cfg_raddr];
    end else begin
      rdata_reg <= '0;
    end
  end

  assign o_cfg_rdata = rdata_reg;
`endif

endmodule
